// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, legal parameter ranges and beat-count helper
// for the parametrised asynchronous SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WBEAT,
      ST_WRECOV,
      ST_RBEAT,
      ST_ACK
   } sram_ctrl_state_e;

   localparam int DATA_W_MIN   = 16;
   localparam int DATA_W_MAX   = 64;
   localparam int WAIT_CYC_MIN = 1;
   localparam int WAIT_CYC_MAX = 15;

   function automatic int beat_count(input int data_w);
      return data_w / 16;
   endfunction

endpackage

// File: rtl/sram_dq_iobuf.sv
// sram_dq_iobuf: 16-bit tri-state driver that keeps the SRAM data inout away from the FSM.
module sram_dq_iobuf (
   inout  wire  [15:0] pad,
   input  logic        oe,
   input  logic [15:0] dout,
   output logic [15:0] din
);

   assign pad = oe ? dout : 16'hzzzz;
   assign din = pad;

endmodule

// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: splits DATA_W-bit requests into 16-bit SRAM beats with programmable wait cycles.
// Define SRAM_CTRL_SKIP_MASKED_EN to skip beats whose byte-enable pair is 00.
module sram_ctrl_param
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 18,
   parameter int WAIT_CYC = 1
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [ADDR_W-1:0]   i_ADDR,
   input  logic [DATA_W-1:0]   i_WDATA,
   input  logic [DATA_W/8-1:0] i_BMASK,
   input  logic                i_WREN,
   input  logic                i_RDEN,
   output logic [DATA_W-1:0]   o_RDATA,
   output logic                o_ACK,
   output logic                o_BUSY,
   output logic [ADDR_W-1:0]   SRAM_ADDR,
   inout  wire  [15:0]         SRAM_DQ,
   output logic                SRAM_CE_N,
   output logic                SRAM_WE_N,
   output logic                SRAM_OE_N,
   output logic                SRAM_LB_N,
   output logic                SRAM_UB_N
);

   localparam int BEATS = beat_count(DATA_W);
   localparam int MW    = DATA_W / 8;
`ifdef SRAM_CTRL_SKIP_MASKED_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   if (!(DATA_W == 16 || DATA_W == 32 || DATA_W == 64) || DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
      $error("sram_ctrl_param: DATA_W must be 16, 32 or 64");
   end
   if (WAIT_CYC < WAIT_CYC_MIN || WAIT_CYC > WAIT_CYC_MAX) begin : g_bad_wait_cyc
      $error("sram_ctrl_param: WAIT_CYC must be in 1..15");
   end

   // {found, index} of the first beat at or above 'from' that has to run
   function automatic logic [2:0] seek(input logic [MW-1:0] m, input int from);
      seek = '0;
      for (int j = BEATS - 1; j >= 0; j--)
         if (j >= from && (!SKIP || m[2*j +: 2] != 2'b00)) seek = {1'b1, 2'(j)};
   endfunction

   sram_ctrl_state_e  st_q, st_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        beat_q, pair;
   logic [3:0]        wait_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, rd_next;
   logic [MW-1:0]     bmask_q;
   logic [2:0]        first, more;
   logic              accept, last_wait, dq_oe;
   logic [15:0]       dq_in;

   assign accept    = st_q == ST_IDLE && (i_WREN ^ i_RDEN);
   assign first     = seek(i_BMASK, 0);
   assign more      = seek(bmask_q, int'(beat_q) + 1);
   assign last_wait = wait_q == 4'(WAIT_CYC - 1);
   assign SRAM_ADDR = addr_q + ADDR_W'(beat_q);
   assign o_RDATA   = rdata_q;

   always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) st_q <= ST_IDLE;
      else st_q <= st_d;

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE:   if (accept) st_d = !first[2] ? ST_ACK : i_WREN ? ST_WBEAT : ST_RBEAT;
         ST_WBEAT:  if (last_wait) st_d = ST_WRECOV;
         ST_WRECOV: st_d = more[2] ? ST_WBEAT : ST_ACK;
         ST_RBEAT:  if (last_wait) st_d = more[2] ? ST_RBEAT : ST_ACK;
         default:   st_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pair                   = bmask_q[2*beat_q +: 2];
      o_BUSY                 = st_q != ST_IDLE;
      o_ACK                  = st_q == ST_ACK;
      SRAM_CE_N              = !(st_q inside {ST_WBEAT, ST_WRECOV, ST_RBEAT});
      SRAM_WE_N              = st_q != ST_WBEAT;
      SRAM_OE_N              = st_q != ST_RBEAT;
      {SRAM_UB_N, SRAM_LB_N} = SRAM_CE_N ? 2'b11 : ~pair;
      dq_oe                  = st_q inside {ST_WBEAT, ST_WRECOV};
   end

   // masked bytes read as 0; skipped slices are cleared alongside the captured one
   always_comb begin
      rd_next = rdata_q;
      for (int j = 0; j < BEATS; j++)
         if (j == int'(beat_q))
            rd_next[16*j +: 16] = {bmask_q[2*j+1] ? dq_in[15:8] : 8'h00, bmask_q[2*j] ? dq_in[7:0] : 8'h00};
         else if (SKIP && bmask_q[2*j +: 2] == 2'b00)
            rd_next[16*j +: 16] = '0;
   end

   always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) begin
         addr_q  <= '0;
         beat_q  <= '0;
         wait_q  <= '0;
         wdata_q <= '0;
         bmask_q <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         addr_q  <= i_ADDR & ~ADDR_W'(BEATS - 1);
         wdata_q <= i_WDATA;
         bmask_q <= i_BMASK;
         beat_q  <= first[1:0];
         wait_q  <= '0;
         if (!first[2] && i_RDEN) rdata_q <= '0;
      end else if (st_q == ST_WBEAT || st_q == ST_RBEAT) begin
         wait_q <= last_wait ? '0 : wait_q + 4'd1;
         if (st_q == ST_RBEAT && last_wait) begin
            rdata_q <= rd_next;
            if (more[2]) beat_q <= more[1:0];
         end
      end else if (st_q == ST_WRECOV && more[2]) beat_q <= more[1:0];

   sram_dq_iobuf u_iobuf (
      .pad  (SRAM_DQ),
      .oe   (dq_oe),
      .dout (wdata_q[16*beat_q +: 16]),
      .din  (dq_in)
   );

endmodule

// File: tb/tb_sram_ctrl_param.sv
// tb_sram_ctrl_param: directed checks of a 32-bit/1-wait and a 64-bit/3-wait controller
// against behavioural asynchronous SRAM models.
module tb_sram_ctrl_param;

`ifdef SRAM_CTRL_SKIP_MASKED_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [17:0] a32, sa32;
   logic [31:0] wd32, rdat32;
   logic [3:0]  m32;
   logic        wr32, rd32, ack32, busy32, ce32, we32, oe32, lb32, ub32;
   wire  [15:0] dq32;
   logic [15:0] mem32 [64];
   int          acks32 = 0, we_cnt32 = 0;

   sram_ctrl_param #(.DATA_W(32), .ADDR_W(18), .WAIT_CYC(1)) u32 (
      .i_clk(clk), .i_reset(rst_n), .i_ADDR(a32), .i_WDATA(wd32), .i_BMASK(m32),
      .i_WREN(wr32), .i_RDEN(rd32), .o_RDATA(rdat32), .o_ACK(ack32), .o_BUSY(busy32),
      .SRAM_ADDR(sa32), .SRAM_DQ(dq32), .SRAM_CE_N(ce32), .SRAM_WE_N(we32),
      .SRAM_OE_N(oe32), .SRAM_LB_N(lb32), .SRAM_UB_N(ub32)
   );

   assign dq32 = (!ce32 && !oe32) ? mem32[sa32[5:0]] : 16'hzzzz;
   always @(posedge we32)
      if (!ce32) begin
         if (!lb32) mem32[sa32[5:0]][7:0] <= dq32[7:0];
         if (!ub32) mem32[sa32[5:0]][15:8] <= dq32[15:8];
      end
   always @(negedge we32) we_cnt32++;
   always @(negedge clk) if (ack32) acks32++;

   logic [17:0] a64, sa64;
   logic [63:0] wd64, rdat64;
   logic [7:0]  m64;
   logic        wr64, rd64, ack64, busy64, ce64, we64, oe64, lb64, ub64;
   wire  [15:0] dq64;
   logic [15:0] mem64 [64];
   logic [17:0] oe_seq [16];
   int          oe_cnt = 0;

   sram_ctrl_param #(.DATA_W(64), .ADDR_W(18), .WAIT_CYC(3)) u64 (
      .i_clk(clk), .i_reset(rst_n), .i_ADDR(a64), .i_WDATA(wd64), .i_BMASK(m64),
      .i_WREN(wr64), .i_RDEN(rd64), .o_RDATA(rdat64), .o_ACK(ack64), .o_BUSY(busy64),
      .SRAM_ADDR(sa64), .SRAM_DQ(dq64), .SRAM_CE_N(ce64), .SRAM_WE_N(we64),
      .SRAM_OE_N(oe64), .SRAM_LB_N(lb64), .SRAM_UB_N(ub64)
   );

   assign dq64 = (!ce64 && !oe64) ? mem64[sa64[5:0]] : 16'hzzzz;
   always @(posedge we64)
      if (!ce64) begin
         if (!lb64) mem64[sa64[5:0]][7:0] <= dq64[7:0];
         if (!ub64) mem64[sa64[5:0]][15:8] <= dq64[15:8];
      end
   always @(negedge clk)
      if (!oe64 && oe_cnt < 16) begin
         oe_seq[oe_cnt] <= sa64;
         oe_cnt <= oe_cnt + 1;
      end

   // called #1 after an edge with the DUT idle; returns in the first IDLE cycle after ACK
   task automatic req32(input logic w, input logic [17:0] a, input logic [31:0] d, input logic [3:0] m, output int lat);
      wr32 = w; rd32 = !w; a32 = a; wd32 = d; m32 = m;
      @(posedge clk); #1;
      wr32 = 1'b0; rd32 = 1'b0; lat = 1;
      while (!ack32 && lat < 40) begin @(posedge clk); #1; lat++; end
      @(posedge clk); #1;
   endtask

   task automatic req64(input logic w, input logic [17:0] a, input logic [63:0] d, input logic [7:0] m, output int lat);
      wr64 = w; rd64 = !w; a64 = a; wd64 = d; m64 = m;
      @(posedge clk); #1;
      wr64 = 1'b0; rd64 = 1'b0; lat = 1;
      while (!ack64 && lat < 60) begin @(posedge clk); #1; lat++; end
      @(posedge clk); #1;
   endtask

   initial begin
      int lat, w0, k0;
      for (int i = 0; i < 64; i++) begin mem32[i] = '0; mem64[i] = '0; end
      {wr32, rd32, wr64, rd64} = '0;
      a32 = '0; wd32 = '0; m32 = '0; a64 = '0; wd64 = '0; m64 = '0;
      repeat (3) @(posedge clk); #1;
      chk("reset_busy", busy32, 0);
      chk("reset_ack", ack32, 0);
      chk("reset_rdata", rdat32, 0);
      chk("reset_addr", sa32, 0);
      chk("reset_strobes", {ce32, we32, oe32, lb32, ub32}, 5'b11111);
      chk("reset_dq_oe", u32.dq_oe, 0);
      chk("reset_rdata64", rdat64, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      w0 = we_cnt32;
      req32(1'b1, 18'h5, 32'hDEADBEEF, 4'hF, lat);
      chk("wr_lat", lat, 5);
      chk("wr_we_pulses", we_cnt32 - w0, 2);
      chk("wr_mem4", mem32[4], 16'hBEEF);
      chk("wr_mem5", mem32[5], 16'hDEAD);

      req32(1'b0, 18'h5, '0, 4'hF, lat);
      chk("rd_lat", lat, 3);
      chk("rd_data", rdat32, 32'hDEADBEEF);
      req32(1'b0, 18'h4, '0, 4'h6, lat);
      chk("rd_mask6", rdat32, 32'h00ADBE00);

      w0 = we_cnt32;
      req32(1'b1, 18'h8, 32'h11112222, 4'hC, lat);
      chk("wr_maskC_lat", lat, SKIP ? 3 : 5);
      chk("wr_maskC_pulses", we_cnt32 - w0, SKIP ? 1 : 2);
      chk("wr_maskC_mem8", mem32[8], 16'h0000);
      chk("wr_maskC_mem9", mem32[9], 16'h1111);

      req32(1'b1, 18'hA, 32'hFFFFFFFF, 4'h0, lat);
      chk("wr_mask0_lat", lat, SKIP ? 1 : 5);
      chk("wr_mask0_memA", mem32[10], 16'h0000);
      chk("wr_mask0_memB", mem32[11], 16'h0000);
      req32(1'b0, 18'h4, '0, 4'h0, lat);
      chk("rd_mask0_lat", lat, SKIP ? 1 : 3);
      chk("rd_mask0_data", rdat32, 32'h0);

      k0 = acks32;
      wr32 = 1'b1; rd32 = 1'b1; a32 = 18'h4; wd32 = 32'h12345678; m32 = 4'hF;
      repeat (3) @(posedge clk); #1;
      chk("both_busy", busy32, 0);
      chk("both_acks", acks32 - k0, 0);
      wr32 = 1'b0; rd32 = 1'b0;

      w0 = we_cnt32; k0 = acks32;
      rd32 = 1'b1; a32 = 18'h4; m32 = 4'hF;
      @(posedge clk); #1;
      rd32 = 1'b0; wr32 = 1'b1; wd32 = 32'h55555555; lat = 1;
      while (!ack32 && lat < 40) begin @(posedge clk); #1; lat++; end
      wr32 = 1'b0;
      @(posedge clk); #1;
      chk("busy_strobe_lat", lat, 3);
      chk("busy_strobe_data", rdat32, 32'hDEADBEEF);
      chk("busy_strobe_pulses", we_cnt32 - w0, 0);
      chk("busy_strobe_acks", acks32 - k0, 1);

      k0 = acks32;
      wr32 = 1'b1; a32 = 18'h10; wd32 = 32'hCAFEF00D; m32 = 4'hF;
      @(posedge clk); #1;
      wr32 = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("mid_second_beat_we", we32, 0);
      chk("mid_second_beat_addr", sa32, 18'h11);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we_ce", {we32, ce32}, 2'b11);
      chk("rst_mid_dq_oe", u32.dq_oe, 0);
      chk("rst_mid_busy", busy32, 0);
      repeat (3) @(posedge clk); #1;
      chk("rst_mid_acks", acks32 - k0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      req32(1'b0, 18'h4, '0, 4'hF, lat);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_data", rdat32, 32'hDEADBEEF);

      req64(1'b1, 18'h21, 64'h0123456789ABCDEF, 8'hFF, lat);
      chk("wr64_lat", lat, 17);
      chk("wr64_mem20", mem64[32], 16'hCDEF);
      chk("wr64_mem23", mem64[35], 16'h0123);
      req64(1'b0, 18'h22, '0, 8'hFF, lat);
      chk("rd64_lat", lat, 13);
      chk("rd64_data", rdat64, 64'h0123456789ABCDEF);
      chk("rd64_oe_cycles", oe_cnt, 12);
      chk("rd64_addr_first", oe_seq[0], 18'h20);
      chk("rd64_addr_beat1", oe_seq[3], 18'h21);
      chk("rd64_addr_last", oe_seq[11], 18'h23);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_ctrl_param.md
# sram_ctrl_param

Parametrised controller between the LSU-side request port and an external 16-bit asynchronous SRAM (IS61WV25616 class). It splits each DATA_W-bit access into DATA_W/16 half-word beats and holds each beat for a programmable number of wait cycles. Write beats are separated by a recovery cycle so that every beat gets a distinct WE_N pulse. It replaces the fixed 32-bit, zero-wait controller in the memory subsystem.

## Interface
- DATA_W, 32, request data width; legal values 16, 32, 64.
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYC, 1, cycles each beat drives the SRAM; legal range 1..15.
- BEATS (local), DATA_W/16, number of half-word beats per request.
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_ADDR  in  ADDR_W  half-word address; the low log2(BEATS) bits are forced to 0.
- i_WDATA  in  DATA_W  write data; beat k uses bits [16k+15:16k].
- i_BMASK  in  DATA_W/8  byte enables; beat k uses bits [2k+1:2k] as {UB,LB}.
- i_WREN / i_RDEN  in  1 each  request strobes; sampled only in IDLE.
- o_RDATA  out  DATA_W  read data, held until the next read completes.
- o_ACK  out  1  one-cycle completion pulse.
- o_BUSY  out  1  high whenever the state is not IDLE.
- SRAM_ADDR  out  ADDR_W; SRAM_DQ  inout  16; SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N  out  1 each.

## Operation
- Request accept: in IDLE, i_WREN xor i_RDEN accepts a request. If both strobes are high or both are low, nothing happens. Strobes outside IDLE are ignored; there is no queueing.
- Registers latched on accept: aligned address, wdata, bmask. The beat counter and the wait counter both clear.
- States: IDLE, WBEAT, WRECOV, RBEAT, ACK.
- WBEAT:
  - CE_N=0, WE_N=0, OE_N=1.
  - DQ drives the current beat's half-word.
  - {UB_N,LB_N} = ~mask pair.
  - Lasts WAIT_CYC cycles, then moves to WRECOV.
- WRECOV:
  - WE_N=1, CE_N=0, DQ still driven (data hold time).
  - Lasts 1 cycle.
  - Then goes to WBEAT for the next beat (address+1), or to ACK after the last beat.
- RBEAT:
  - CE_N=0, OE_N=0, WE_N=1, DQ hi-Z.
  - Lasts WAIT_CYC cycles.
  - On the final cycle's edge, DQ is captured into o_RDATA slice k; bytes with mask bit 0 are written as 0.
  - Then goes to the next beat (address+1), or to ACK.
- ACK: o_ACK=1, all SRAM strobes inactive, DQ hi-Z. Returns to IDLE next cycle.
- SRAM_ADDR = registered base + beat index. No address changes while WE_N=0.
- DQ is driven only in WBEAT/WRECOV; otherwise it is hi-Z.

## Timing
- Cycle 0 is the accept edge. The first beat cycle is cycle 1.
- Read latency to o_ACK: BEATS*WAIT_CYC+1 cycles (3 for the defaults).
- Write latency to o_ACK: BEATS*(WAIT_CYC+1)+1 cycles (5 for the defaults).
- o_RDATA is valid in the ACK cycle and stays stable until the next read's capture.
- Back-to-back: the next request can be accepted on the cycle after ACK (the first IDLE cycle).
- Reset values:
  - State IDLE; o_ACK=0; o_BUSY=0; o_RDATA=0; SRAM_ADDR=0.
  - All *_N outputs = 1; DQ hi-Z.
- Reset mid-access: all strobes deassert asynchronously and the access is abandoned with no ACK. The SRAM content of the partially written word is undefined.

## Configuration
- SRAM_CTRL_SKIP_MASKED_EN defined:
  - Beats whose mask pair is 00 are skipped entirely (no cycles spent), and the matching o_RDATA slice is written 0.
  - A request with an all-zero mask goes from accept directly to ACK, giving latency 1.
- Undefined: every beat executes with UB_N=LB_N=1 when its mask is 00, so latency is always the full formula.

## Structure
- Package sram_ctrl_pkg holds:
  - the sram_ctrl_state_e enum;
  - the legal-range constants for DATA_W and WAIT_CYC;
  - a beat-count helper function.
- Elaboration-time assertions reject illegal DATA_W and WAIT_CYC values.
- One sub-module, sram_dq_iobuf: the 16-bit tri-state driver taking an output-enable and out/in data, isolating the inout from the FSM.

## Test plan
- DATA_W=32, WAIT_CYC=1: write 0xDEADBEEF, mask 0xF, address 0x00005 -> SRAM 0x00004=0xBEEF and 0x00005=0xDEAD; two separate WE_N pulses; o_ACK at cycle 5.
- Read back the same address -> o_RDATA=0xDEADBEEF, o_ACK at cycle 3. Read with mask 0x6 -> 0x00ADBE00.
- DATA_W=64, WAIT_CYC=3 read -> o_ACK at cycle 13; OE_N low for 12 cycles; SRAM_ADDR steps base..base+3.
- i_WREN=i_RDEN=1 in IDLE, and any strobe while busy -> no state change and no ACK.
- With SRAM_CTRL_SKIP_MASKED_EN: 32-bit write, mask 0xC -> a single WBEAT at address+1, o_ACK at cycle 3. Mask 0x0 -> o_ACK at cycle 1.
- Reset asserted during the second WBEAT -> WE_N/CE_N go to 1 immediately, DQ hi-Z, no o_ACK. After release, a new read completes normally.
